icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Miss-refill controller for the set-associative instruction cache. It is the consumer side of the PLRU replacement interface. On each miss it samples the victim way from the PLRU block and fetches the full line from memory as a single read burst. It writes the line into the victim way's data and tag RAMs, then returns a one-hot access/update pulse to the PLRU so the refilled way becomes most-recently-used. There is no write-back path: the I-cache holds no dirty lines.

## Interface
- ASSOC_NUM, 4, number of ways; legal values are 2 and 4.
- LINE_WORDS, 8, number of 32-bit words per line; must be a power of 2, at least 2.
- INDEX_W, 7, set-index width.
- TAG_W, 32-INDEX_W-$clog2(LINE_WORDS)-2, tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- miss_valid  in  1  a miss request is pending.
- miss_ready  out  1  high only in IDLE.
- miss_addr  in  32  byte address of the missing fetch.
- lru_way  in  $clog2(ASSOC_NUM)  victim way from the PLRU.
- plru_access  out  ASSOC_NUM  one-hot refilled way; zero when plru_update=0.
- plru_update  out  1  single-cycle PLRU update strobe.
- mem_rd_req  out  1  burst read request.
- mem_rd_addr  out  32  line-aligned burst address.
- mem_rd_gnt  in  1  request accepted.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data.
- data_we  out  ASSOC_NUM  per-way data RAM write enable.
- data_index  out  INDEX_W  set index for data and tag writes.
- data_word  out  $clog2(LINE_WORDS)  word offset within the line.
- data_wdata  out  32  data written to the data RAM.
- tag_we  out  ASSOC_NUM  per-way tag+valid write enable.
- tag_wdata  out  TAG_W+1  {valid=1, tag}.
- refill_done  out  1  single-cycle pulse when the line is committed.

## Operation
- FSM states: IDLE, REQ, RECV, COMMIT.
- IDLE -> REQ on miss_valid && miss_ready. In that cycle the controller latches the following into registers:
  - the tag and index fields of miss_addr;
  - lru_way as victim_way.
- Later changes of lru_way have no effect on the refill in progress.
- REQ: drives mem_rd_req=1 and mem_rd_addr={tag, index, 0...0}. Both are held stable until mem_rd_gnt. REQ -> RECV on mem_rd_gnt, and the beat counter is cleared to 0.
- RECV: each mem_rvalid beat does the following in the same cycle:
  - data_we[victim_way]=1, data_word=counter, data_wdata=mem_rdata;
  - the counter increments.
- RECV exit: RECV -> COMMIT on the beat where counter==LINE_WORDS-1. The counter wraps to 0.
- Word order is ascending from word 0; there is no critical-word-first.
- COMMIT (exactly 1 cycle) drives:
  - tag_we[victim_way]=1;
  - plru_update=1 and plru_access=1<<victim_way;
  - refill_done=1.
- COMMIT -> IDLE unconditionally.
- mem_rvalid outside RECV is ignored, and mem_rd_gnt outside REQ is ignored.
- Tag is written last, so a partially filled line is never visible as valid.

## Timing
- Reset values:
  - state=IDLE, so miss_ready=1;
  - mem_rd_req=0;
  - all enables, plru_update and refill_done = 0;
  - counter and latched registers = 0.
- All outputs are decoded from registered state and registered fields. There are no combinational paths from the mem_* inputs to mem_rd_req.
- The data_we path is the exception: it is combinational from mem_rvalid in RECV.
- Latency: with the accept in cycle 0, a grant in cycle g and beats in cycles b0..b(LINE_WORDS-1):
  - COMMIT is in cycle b(LINE_WORDS-1)+1;
  - miss_ready returns high in the following cycle.
- Minimum latency, with grant in cycle 1 and back-to-back beats from cycle 2:
  - COMMIT in cycle LINE_WORDS+2;
  - next accept in cycle LINE_WORDS+3.
- Back-to-back misses: miss_valid held high during a refill is not accepted until IDLE.
- Reset asserted mid-refill:
  - the FSM returns to IDLE immediately (asynchronous) and all write enables deassert;
  - the tag is never written, so the partial line stays invalid;
  - beats still arriving from memory after reset are ignored.

## Structure
- Shared cache package (existing Cache_Defines) carries:
  - the refill_state_t enum (IDLE/REQ/RECV/COMMIT);
  - derived width localparams (OFFSET_W, TAG_W).
- The way binary-to-one-hot decode is a small sub-module, way_onehot. It is reused for data_we, tag_we and plru_access.
- The PLRU instance is external. It is connected as follows:
  - lru_way <- PLRU lru;
  - plru_access and plru_update -> PLRU access and update.

## Test plan
- Reset, then a miss at 0x1234_5660 with lru_way=2, grant in cycle 1, beats D0..D7 back-to-back:
  - mem_rd_addr=0x1234_5660;
  - data_we=4'b0100 with data_word 0..7;
  - COMMIT in cycle 10 with tag_we=4'b0100, plru_access=4'b0100, refill_done=1.
- lru_way changes from 2 to 0 one cycle after accept -> all writes still target way 2.
- Grant delayed 5 cycles and beats with 1-cycle gaps -> mem_rd_req/addr stable until grant; exactly 8 data writes, no write in gap cycles.
- mem_rvalid pulsed while in IDLE and REQ -> no data_we and no counter change.
- Reset asserted after beat 3 -> outputs at reset values the same cycle; tag_we never asserted; the next miss refills cleanly from word 0.
- Two consecutive misses with miss_valid held high -> the second is accepted only the cycle after refill_done, and plru_update is pulsed once per refill.

Source files
------------

// File: rtl/Cache_Defines.sv
// Shared I-cache types and default geometry: refill FSM states and derived address-field widths.
// Pure declarations, no logic and no latency.
package Cache_Defines;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RECV   = 2'd2,
        COMMIT = 2'd3
    } refill_state_t;

    localparam int ASSOC_NUM_DEF  = 4;
    localparam int LINE_WORDS_DEF = 8;
    localparam int INDEX_W_DEF    = 7;
    localparam int OFFSET_W       = $clog2(LINE_WORDS_DEF);
    localparam int TAG_W          = 32 - INDEX_W_DEF - OFFSET_W - 2;

    function automatic int tag_width(input int index_w, input int line_words);
        return 32 - index_w - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/way_onehot.sv
// Binary way number to one-hot way select; purely combinational, zero latency.
// No flow control: the caller gates the result with its own enable.
module way_onehot #(
    parameter int WAYS = 4
) (
    input  logic [$clog2(WAYS)-1:0] way,
    output logic [WAYS-1:0]         onehot
);

    always_comb begin
        onehot      = '0;
        onehot[way] = 1'b1;
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill: one burst per miss into the PLRU victim way, tag committed last; COMMIT at last beat + 1.
// Backpressure: miss_ready only in IDLE; burst request held until grant; beats accepted whenever they arrive in RECV.
module icache_refill_ctrl
    import Cache_Defines::*;
#(
    parameter int ASSOC_NUM  = ASSOC_NUM_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int INDEX_W    = INDEX_W_DEF,
    parameter int TAG_W      = tag_width(INDEX_W, LINE_WORDS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [31:0]                   miss_addr,
    input  logic [$clog2(ASSOC_NUM)-1:0]  lru_way,
    output logic [ASSOC_NUM-1:0]          plru_access,
    output logic                          plru_update,
    output logic                          mem_rd_req,
    output logic [31:0]                   mem_rd_addr,
    input  logic                          mem_rd_gnt,
    input  logic                          mem_rvalid,
    input  logic [31:0]                   mem_rdata,
    output logic [ASSOC_NUM-1:0]          data_we,
    output logic [INDEX_W-1:0]            data_index,
    output logic [$clog2(LINE_WORDS)-1:0] data_word,
    output logic [31:0]                   data_wdata,
    output logic [ASSOC_NUM-1:0]          tag_we,
    output logic [TAG_W:0]                tag_wdata,
    output logic                          refill_done
);

    localparam int WAY_W = $clog2(ASSOC_NUM);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    refill_state_t state, state_nxt;

    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [WAY_W-1:0]   victim_way;
    logic [OFF_W-1:0]   counter;
    logic               beat_we;
    logic               commit;
    logic [ASSOC_NUM-1:0] victim_onehot;

    // Byte and word offset bits of the miss address are irrelevant: the whole line is fetched.
    logic unused_offset;
    assign unused_offset = ^miss_addr[OFF_W+1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        miss_ready = 1'b0;
        mem_rd_req = 1'b0;
        beat_we    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_nxt = REQ;
            end
            REQ: begin
                mem_rd_req = 1'b1;
                if (mem_rd_gnt) state_nxt = RECV;
            end
            RECV: begin
                beat_we = mem_rvalid;
                if (mem_rvalid && counter == LAST_WORD) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q      <= '0;
            index_q    <= '0;
            victim_way <= '0;
            counter    <= '0;
        end else begin
            // Victim is frozen at accept so later PLRU movement cannot redirect the refill.
            if (state == IDLE && miss_valid) begin
                tag_q      <= miss_addr[31 -: TAG_W];
                index_q    <= miss_addr[OFF_W+2 +: INDEX_W];
                victim_way <= lru_way;
            end
            if (state == REQ && mem_rd_gnt) counter <= '0;
            else if (beat_we)               counter <= counter + 1'b1;
        end
    end

    way_onehot #(
        .WAYS   (ASSOC_NUM)
    ) u_way_onehot (
        .way    (victim_way),
        .onehot (victim_onehot)
    );

    assign mem_rd_addr = {tag_q, index_q, {(OFF_W + 2){1'b0}}};
    assign data_we     = beat_we ? victim_onehot : '0;
    assign data_index  = index_q;
    assign data_word   = counter;
    assign data_wdata  = mem_rdata;
    assign tag_we      = commit ? victim_onehot : '0;
    assign tag_wdata   = {1'b1, tag_q};
    assign plru_access = commit ? victim_onehot : '0;
    assign plru_update = commit;
    assign refill_done = commit;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: min-latency refill, victim freeze, delayed grant with gapped beats,
// stray beats, mid-refill reset and back-to-back misses.
module tb_icache_refill_ctrl;

    localparam int ASSOC_NUM  = 4;
    localparam int LINE_WORDS = 8;
    localparam int INDEX_W    = 7;
    localparam int TAG_W      = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic [1:0]  lru_way;
    logic [3:0]  plru_access;
    logic        plru_update;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [3:0]  data_we;
    logic [6:0]  data_index;
    logic [2:0]  data_word;
    logic [31:0] data_wdata;
    logic [3:0]  tag_we;
    logic [20:0] tag_wdata;
    logic        refill_done;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int we_cnt = 0;
    int tag_cnt = 0;

    icache_refill_ctrl #(
        .ASSOC_NUM   (ASSOC_NUM),
        .LINE_WORDS  (LINE_WORDS),
        .INDEX_W     (INDEX_W),
        .TAG_W       (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .miss_valid  (miss_valid),
        .miss_ready  (miss_ready),
        .miss_addr   (miss_addr),
        .lru_way     (lru_way),
        .plru_access (plru_access),
        .plru_update (plru_update),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_gnt  (mem_rd_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .data_we     (data_we),
        .data_index  (data_index),
        .data_word   (data_word),
        .data_wdata  (data_wdata),
        .tag_we      (tag_we),
        .tag_wdata   (tag_wdata),
        .refill_done (refill_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (plru_update) upd_cnt++;
        if (|data_we)    we_cnt++;
        if (|tag_we)     tag_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] addr, input int k);
        return 32'hA5C3_0000 ^ addr ^ 32'(k * 32'h0101_0101);
    endfunction

    // Entered mid-cycle with the DUT in IDLE; returns mid-cycle in the cycle after COMMIT.
    task automatic refill(input logic [31:0] addr, input logic [1:0] way, input logic [1:0] way_after,
                          input int gnt_dly, input int gap, input bit hold_valid, input bit rv_in_req);
        logic [31:0] exp_addr;
        logic [3:0]  exp_oh;
        int          we_start;
        exp_addr = {addr[31:5], 5'b0};
        exp_oh   = 4'b0001 << way;
        we_start = we_cnt;
        miss_valid = 1'b1;
        miss_addr  = addr;
        lru_way    = way;
        #1 chk("accept_ready", 64'(miss_ready), 64'(1));
        step();
        miss_valid = hold_valid;
        lru_way    = way_after;
        if (!hold_valid) miss_addr = ~addr;
        for (int i = 0; i < gnt_dly; i++) begin
            mem_rvalid = rv_in_req;
            #1;
            chk("req_wait", 64'(mem_rd_req), 64'(1));
            chk("req_addr_wait", 64'(mem_rd_addr), 64'(exp_addr));
            chk("req_no_we", 64'(data_we), 64'(0));
            step();
        end
        mem_rvalid = 1'b0;
        mem_rd_gnt = 1'b1;
        #1;
        chk("req", 64'(mem_rd_req), 64'(1));
        chk("req_addr", 64'(mem_rd_addr), 64'(exp_addr));
        chk("busy_ready", 64'(miss_ready), 64'(0));
        step();
        mem_rd_gnt = 1'b0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            for (int g = 0; g < gap; g++) begin
                mem_rvalid = 1'b0;
                #1 chk("gap_no_we", 64'(data_we), 64'(0));
                step();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat_data(addr, k);
            #1;
            chk("beat_we", 64'(data_we), 64'(exp_oh));
            chk("beat_word", 64'(data_word), 64'(k));
            chk("beat_wdata", 64'(data_wdata), 64'(beat_data(addr, k)));
            chk("beat_index", 64'(data_index), 64'(addr[11:5]));
            chk("beat_no_tag", 64'(tag_we), 64'(0));
            chk("beat_ready", 64'(miss_ready), 64'(0));
            step();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("commit_tag_we", 64'(tag_we), 64'(exp_oh));
        chk("commit_tag_wdata", 64'(tag_wdata), 64'({1'b1, addr[31:12]}));
        chk("commit_plru_access", 64'(plru_access), 64'(exp_oh));
        chk("commit_plru_update", 64'(plru_update), 64'(1));
        chk("commit_done", 64'(refill_done), 64'(1));
        chk("commit_no_we", 64'(data_we), 64'(0));
        chk("commit_ready", 64'(miss_ready), 64'(0));
        step();
        chk("after_ready", 64'(miss_ready), 64'(1));
        chk("after_update", 64'(plru_update), 64'(0));
        chk("after_access", 64'(plru_access), 64'(0));
        chk("after_done", 64'(refill_done), 64'(0));
        chk("write_count", 64'(we_cnt - we_start), 64'(LINE_WORDS));
    endtask

    initial begin
        int upd_start;
        int tag_start;
        reset      = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        lru_way    = '0;
        mem_rd_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        chk("rst_ready", 64'(miss_ready), 64'(1));
        chk("rst_req", 64'(mem_rd_req), 64'(0));
        chk("rst_addr", 64'(mem_rd_addr), 64'(0));
        chk("rst_data_we", 64'(data_we), 64'(0));
        chk("rst_tag_we", 64'(tag_we), 64'(0));
        chk("rst_update", 64'(plru_update), 64'(0));
        chk("rst_done", 64'(refill_done), 64'(0));
        chk("rst_word", 64'(data_word), 64'(0));
        reset = 1'b0;
        step();

        // Minimum latency refill (COMMIT in cycle 10), victim changes 2->0 after accept.
        refill(32'h1234_5660, 2'd2, 2'd0, 0, 0, 1'b0, 1'b0);

        // Stray beat while idle.
        mem_rvalid = 1'b1;
        #1;
        chk("idle_beat_we", 64'(data_we), 64'(0));
        chk("idle_beat_ready", 64'(miss_ready), 64'(1));
        step();
        mem_rvalid = 1'b0;

        // Grant delayed 5 cycles with stray beats in REQ, then gapped beats.
        refill(32'h0000_ABC0, 2'd1, 2'd3, 5, 1, 1'b0, 1'b1);

        // Reset after beat 3 of a refill.
        tag_start  = tag_cnt;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_1000;
        lru_way    = 2'd3;
        step();
        miss_valid = 1'b0;
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'(k);
            #1 chk("pre_rst_word", 64'(data_word), 64'(k));
            step();
        end
        mem_rdata = 32'h4;
        reset     = 1'b1;
        #1;
        chk("midrst_data_we", 64'(data_we), 64'(0));
        chk("midrst_ready", 64'(miss_ready), 64'(1));
        chk("midrst_req", 64'(mem_rd_req), 64'(0));
        chk("midrst_word", 64'(data_word), 64'(0));
        chk("midrst_tag_we", 64'(tag_we), 64'(0));
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_beat_we", 64'(data_we), 64'(0));
            chk("post_rst_ready", 64'(miss_ready), 64'(1));
            step();
        end
        mem_rvalid = 1'b0;
        chk("midrst_no_tag_write", 64'(tag_cnt - tag_start), 64'(0));
        refill(32'h0000_2000, 2'd3, 2'd3, 0, 0, 1'b0, 1'b0);

        // Back-to-back misses with miss_valid held high.
        upd_start = upd_cnt;
        refill(32'h0F00_0040, 2'd0, 2'd1, 0, 0, 1'b1, 1'b0);
        refill(32'h0F00_0080, 2'd1, 2'd1, 0, 0, 1'b0, 1'b0);
        chk("b2b_update_pulses", 64'(upd_cnt - upd_start), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
